// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1/8N2 transmitter that drains a byte FIFO. It pops one byte per frame
// and sends it LSB first, with txd driven straight from a flop.
module uart_tx_fifo_drain #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_fifo_read_ready,
  input  logic [7:0] i_fifo_read_data,
  output logic       o_fifo_read_enable,
  output logic       o_txd,
  output logic       o_busy
);

  localparam int unsigned     CNT_W     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_PER_BIT - 1);
  // The bit index is reused to count stop bits once the data bits are done.
  localparam logic [2:0]      STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_baud;
  logic [CNT_W-1:0] w_baud_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_txd;
  logic             w_txd_next;
  logic             w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Next-state, baud counter, bit index and shift register.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = {CNT_W{1'b0}};
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    case (r_state)
      S_IDLE: begin
        w_bit_idx_next = 3'd0;
        if (i_fifo_read_ready) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        w_shift_next = i_fifo_read_data;
        w_state_next = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = 3'd0;
            w_state_next   = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit_idx == STOP_LAST) begin
            w_bit_idx_next = 3'd0;
            if (i_fifo_read_ready) begin
              w_state_next = S_FETCH;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + CNT_W'(1);
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_bit_idx_next = 3'd0;
      end
    endcase
  end

  // txd is precomputed from the next state so the pin flop lines up with the state.
  always_comb begin
    w_txd_next = 1'b1;
    case (w_state_next)
      S_START: w_txd_next = 1'b0;
      S_DATA:  w_txd_next = w_shift_next[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_baud    <= {CNT_W{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_txd     <= w_txd_next;
    end
  end

  assign o_txd              = r_txd;
  assign o_fifo_read_enable = (r_state == S_FETCH);
  assign o_busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain: FIFO models feed two instances (1 and 2 stop bits),
// and every popped byte is expanded into its expected per-cycle txd waveform.
module tb_uart_tx_fifo_drain;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rdy1, rdy2, en1, en2, txd1, txd2, busy1, busy2;
  logic [7:0] dat1, dat2;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.CLK_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_fifo_read_ready(rdy1), .i_fifo_read_data(dat1),
    .o_fifo_read_enable(en1), .o_txd(txd1), .o_busy(busy1));

  uart_tx_fifo_drain #(.CLK_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_fifo_read_ready(rdy2), .i_fifo_read_data(dat2),
    .o_fifo_read_enable(en2), .o_txd(txd2), .o_busy(busy2));

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         pops1 = 0, pops2 = 0;
  int         busy_cnt1 = 0, busy_cnt2 = 0, low_cnt2 = 0;
  int         last_pop1 = -1, pop_gap1 = 0;
  logic [7:0] q1[$], q2[$];
  logic [7:0] sb1[$], sb2[$];
  logic       str1[$], str2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    q1.push_back(b);
    sb1.push_back(b);
    rdy1 = 1'b1;
    dat1 = q1[0];
  endtask

  task automatic push2(input logic [7:0] b);
    q2.push_back(b);
    sb2.push_back(b);
    rdy2 = 1'b1;
    dat2 = q2[0];
  endtask

  // One clock: check outputs at negedge, then update the registered FIFO models after posedge.
  task automatic tick();
    logic       e, nb, s_en1, s_en2;
    logic [7:0] b;
    @(negedge clk);
    s_en1 = en1;
    s_en2 = en2;
    nb = (str1.size() != 0);
    e  = nb ? str1.pop_front() : 1'b1;
    chk("txd1", 32'(txd1), 32'(e));
    if (nb) chk("busy1_in_frame", 32'(busy1), 32'd1);
    if (s_en1) begin
      chk("pop1_while_ready", 32'(rdy1), 32'd1);
      chk("pop1_once_per_frame", 32'(str1.size()), 32'd0);
      chk("pop1_expected", 32'(sb1.size() != 0), 32'd1);
      b = (sb1.size() != 0) ? sb1.pop_front() : 8'h00;
      pops1++;
      if (last_pop1 >= 0) pop_gap1 = cyc - last_pop1;
      last_pop1 = cyc;
      for (int i = 0; i < 4; i++) str1.push_back(1'b0);
      for (int k = 0; k < 8; k++) for (int i = 0; i < 4; i++) str1.push_back(b[k]);
      for (int i = 0; i < 4; i++) str1.push_back(1'b1);
    end
    nb = (str2.size() != 0);
    e  = nb ? str2.pop_front() : 1'b1;
    chk("txd2", 32'(txd2), 32'(e));
    if (nb) chk("busy2_in_frame", 32'(busy2), 32'd1);
    if (s_en2) begin
      chk("pop2_while_ready", 32'(rdy2), 32'd1);
      chk("pop2_once_per_frame", 32'(str2.size()), 32'd0);
      chk("pop2_expected", 32'(sb2.size() != 0), 32'd1);
      b = (sb2.size() != 0) ? sb2.pop_front() : 8'h00;
      pops2++;
      for (int i = 0; i < 4; i++) str2.push_back(1'b0);
      for (int k = 0; k < 8; k++) for (int i = 0; i < 4; i++) str2.push_back(b[k]);
      for (int i = 0; i < 8; i++) str2.push_back(1'b1);
    end
    if (busy1) busy_cnt1++;
    if (busy2) busy_cnt2++;
    if (!txd2) low_cnt2++;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      str1.delete();
      str2.delete();
    end
    #1;
    if (s_en1 && q1.size() != 0) void'(q1.pop_front());
    if (s_en2 && q2.size() != 0) void'(q2.pop_front());
    rdy1 = (q1.size() != 0);
    dat1 = rdy1 ? q1[0] : 8'h00;
    rdy2 = (q2.size() != 0);
    dat2 = rdy2 ? q2[0] : 8'h00;
  endtask

  initial begin
    int rel_cyc, p;
    reset_n = 1'b0;
    rdy1 = 1'b0; dat1 = 8'h00;
    rdy2 = 1'b0; dat2 = 8'h00;
    @(posedge clk);
    #1;

    // T1: reset held with ready=1, outputs stay quiet
    push1(8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_busy", 32'(busy1), 32'd0);
      chk("t1_rd_en", 32'(en1), 32'd0);
      chk("t1_pops", 32'(pops1), 32'd0);
    end

    // T2: single byte 0x55, pop on the cycle after ready is seen, busy 41 cycles
    reset_n = 1'b1;
    rel_cyc = cyc;
    busy_cnt1 = 0;
    repeat (60) tick();
    chk("t2_pops", 32'(pops1), 32'd1);
    chk("t2_pop_latency", 32'(last_pop1), 32'(rel_cyc + 1));
    chk("t2_busy_cycles", 32'(busy_cnt1), 32'd41);
    chk("t2_idle", 32'(busy1), 32'd0);

    // T3: back-to-back bytes, pops 41 cycles apart
    p = pops1;
    last_pop1 = -1;
    push1(8'hA5);
    push1(8'h3C);
    repeat (100) tick();
    chk("t3_pops", 32'(pops1), 32'(p + 2));
    chk("t3_pop_gap", 32'(pop_gap1), 32'd41);
    chk("t3_idle", 32'(busy1), 32'd0);

    // T4: two stop bits, 0xFF -> 4 low cycles in a 44-cycle frame
    busy_cnt2 = 0;
    low_cnt2 = 0;
    push2(8'hFF);
    repeat (60) tick();
    chk("t4_pops", 32'(pops2), 32'd1);
    chk("t4_low_cycles", 32'(low_cnt2), 32'd4);
    chk("t4_busy_cycles", 32'(busy_cnt2), 32'd45);
    chk("t4_idle", 32'(busy2), 32'd0);

    // T5: reset in cycle 15 of a 0x00 frame aborts it without another pop
    p = pops1;
    push1(8'h00);
    for (int i = 0; i < 5 && pops1 == p; i++) tick();
    chk("t5_pop", 32'(pops1), 32'(p + 1));
    repeat (14) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_abort_busy", 32'(busy1), 32'd0);
    chk("t5_abort_txd", 32'(txd1), 32'd1);
    busy_cnt1 = 0;
    repeat (50) tick();
    chk("t5_no_activity", 32'(busy_cnt1), 32'd0);
    chk("t5_pops_unchanged", 32'(pops1), 32'(p + 1));

    // T6: ready falls once the FIFO drains, frame still completes, no spurious pop
    p = pops1;
    push1(8'hC3);
    repeat (20) tick();
    chk("t6_ready_dropped", 32'(rdy1), 32'd0);
    chk("t6_busy_mid", 32'(busy1), 32'd1);
    repeat (40) tick();
    chk("t6_pops", 32'(pops1), 32'(p + 1));
    chk("t6_idle", 32'(busy1), 32'd0);

    // T7: a byte written mid-frame leaves the byte in flight intact and follows back-to-back
    p = pops1;
    last_pop1 = -1;
    push1(8'h81);
    repeat (20) tick();
    push1(8'h7E);
    repeat (100) tick();
    chk("t7_pops", 32'(pops1), 32'(p + 2));
    chk("t7_pop_gap", 32'(pop_gap1), 32'd41);
    chk("t7_scoreboard_empty", 32'(sb1.size()), 32'd0);
    chk("t7_idle", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
